// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf_pkg
//  Description : Shared definitions for the BF jump-table builder and core:
//                opcode byte values, scan FSM state codes, error codes.
//  Revision    : 1.0  initial release
// ============================================================================
package bf_pkg;

    // BF opcode bytes
    localparam logic [7:0] OP_OPEN  = 8'h5B;   // [
    localparam logic [7:0] OP_CLOSE = 8'h5D;   // ]
    localparam logic [7:0] OP_INC   = 8'h2B;   // +
    localparam logic [7:0] OP_DEC   = 8'h2D;   // -
    localparam logic [7:0] OP_RIGHT = 8'h3E;   // >
    localparam logic [7:0] OP_LEFT  = 8'h3C;   // <
    localparam logic [7:0] OP_OUT   = 8'h2E;   // .
    localparam logic [7:0] OP_IN    = 8'h2C;   // ,

    // Scan FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_POPW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNDERFLOW = 2'b01,   // ']' with empty stack
        ERR_OVERFLOW  = 2'b10,   // '[' with full stack
        ERR_UNMATCHED = 2'b11    // '[' still open at end of program
    } err_code_e;

endpackage
`default_nettype wire

// File: rtl/bf_jump_table_builder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bf_jump_table_builder_if
//  Description : Bundle of the builder's control, program-read, jump-table
//                write and status signals.
//                master : the builder (drives address, table write, status)
//                slave  : the environment (drives start and program data)
//  Revision    : 1.0  initial release
// ============================================================================
interface bf_jump_table_builder_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] prog_rd_addr;
    logic [7:0]        prog_rd_data;
    logic              jt_we;
    logic [ADDR_W-1:0] jt_addr;
    logic [ADDR_W-1:0] jt_wr;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        input  start, prog_rd_data,
        output prog_rd_addr, jt_we, jt_addr, jt_wr,
        output busy, done, err, err_code, err_addr
    );

    modport slave (
        output start, prog_rd_data,
        input  prog_rd_addr, jt_we, jt_addr, jt_wr,
        input  busy, done, err, err_code, err_addr
    );
endinterface
`default_nettype wire

// File: rtl/bf_jump_table_builder_bracket_stack.sv
`default_nettype none
// ============================================================================
//  Module      : bracket_stack
//  Description : Synchronous LIFO holding addresses of open brackets.
//                clk/resetn : clock, async active-low reset (clears sp)
//                clear      : synchronous empty
//                push/din   : push din (ignored when full)
//                pop        : drop top entry (ignored when empty)
//                top/second : topmost and next-below entries
//                sp/full/empty : occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module bracket_stack #(
    parameter  int DEPTH  = 64,
    parameter  int DATA_W = 12,
    localparam int SP_W   = $clog2(DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              clear,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] top,
    output logic      [DATA_W-1:0] second,
    output logic      [SP_W-1:0]   sp,
    output logic                   full,
    output logic                   empty
);
    localparam int IDX_W = SP_W - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [IDX_W-1:0]  idx;

    // Low bits of sp address the next free slot; when sp==DEPTH they wrap
    // to 0, so idx-1 still lands on the last filled slot.
    assign idx    = sp_q[IDX_W-1:0];
    assign top    = mem[idx - IDX_W'(1)];
    assign second = mem[idx - IDX_W'(2)];
    assign sp     = sp_q;
    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[idx] <= din;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bf_jump_table_builder.sv
`default_nettype none
// ============================================================================
//  Module      : bf_jump_table_builder
//  Description : Scans program memory 0..PROG_LEN after start, pairs '[' and
//                ']' through a bracket stack and writes a symmetric jump
//                table (jt[open]=close, jt[close]=open). Unbalanced programs
//                and nesting overflow abort with err/err_code/err_addr.
//                clk, resetn : clock, async active-low reset
//                bus.start   : single-cycle scan request
//                bus.prog_*  : synchronous program memory read port
//                bus.jt_*    : jump-table write port
//                bus.busy/done/err/err_code/err_addr : status
//  Revision    : 1.0  initial release
// ============================================================================
module bf_jump_table_builder
    import bf_pkg::*;
#(
    parameter int PROG_ADDR_WIDTH = 12,
    parameter int PROG_LEN        = 4095,
    parameter int STACK_DEPTH     = 64
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    bf_jump_table_builder_if.master bus
);
    localparam int                         AW       = PROG_ADDR_WIDTH;
    localparam int                         SP_W     = $clog2(STACK_DEPTH) + 1;
    localparam logic [PROG_ADDR_WIDTH-1:0] LAST_ADR = PROG_ADDR_WIDTH'(PROG_LEN);

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic          busy_q, done_q, err_q, jt_we_q;
    logic [AW-1:0] jt_addr_q, jt_wr_q, err_addr_q;
    err_code_e     err_code_q;

    logic          is_open, is_close, push, pop, clear, advance;
    logic          adv_empty;
    logic [AW-1:0] adv_top;
    logic [AW-1:0] top, second;
    logic [SP_W-1:0] sp;
    logic          full, empty;

    bracket_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (AW)
    ) u_stack (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .din    (addr),
        .top    (top),
        .second (second),
        .sp     (sp),
        .full   (full),
        .empty  (empty)
    );

    assign is_open  = (bus.prog_rd_data == OP_OPEN);
    assign is_close = (bus.prog_rd_data == OP_CLOSE);
    assign clear    = bus.start && !busy_q;
    assign push     = (state == ST_SCAN) && is_open && !full;
    assign pop      = (state == ST_POPW);
    assign advance  = pop || ((state == ST_SCAN) && ((is_open && !full) || (!is_open && !is_close)));

    // Stack status as it will be after this cycle's push/pop, used by the
    // end-of-program check so it does not need an extra cycle.
    always_comb begin
        adv_empty = empty;
        adv_top   = top;
        if (pop) begin
            adv_empty = (sp == SP_W'(1));
            adv_top   = second;
        end else if (push) begin
            adv_empty = 1'b0;
            adv_top   = addr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            addr       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
            jt_we_q    <= 1'b0;
            jt_addr_q  <= '0;
            jt_wr_q    <= '0;
        end else begin
            jt_we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        addr       <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        err_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_SCAN;
                ST_SCAN: begin
                    if (is_open && full) begin
                        err_code_q <= ERR_OVERFLOW;
                        err_addr_q <= addr;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= ST_ERROR;
                    end else if (is_close && empty) begin
                        err_code_q <= ERR_UNDERFLOW;
                        err_addr_q <= addr;
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= ST_ERROR;
                    end else if (is_close) begin
                        jt_we_q   <= 1'b1;
                        jt_addr_q <= addr;
                        jt_wr_q   <= top;
                        state     <= ST_POPW;
                    end
                end
                ST_POPW: begin
                    jt_we_q   <= 1'b1;
                    jt_addr_q <= top;
                    jt_wr_q   <= addr;
                end
                default: state <= ST_IDLE;
            endcase

            // Compare before increment so addr never wraps at the top of
            // the address space.
            if (advance) begin
                if (addr == LAST_ADR) begin
                    busy_q <= 1'b0;
                    if (adv_empty) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_UNMATCHED;
                        err_addr_q <= adv_top;
                        state      <= ST_ERROR;
                    end
                end else begin
                    addr  <= addr + AW'(1);
                    state <= ST_FETCH;
                end
            end
        end
    end

    assign bus.prog_rd_addr = addr;
    assign bus.jt_we        = jt_we_q;
    assign bus.jt_addr      = jt_addr_q;
    assign bus.jt_wr        = jt_wr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
    assign bus.err_addr     = err_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_bf_jump_table_builder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf_jump_table_builder
//  Description : Scoreboard bench for bf_jump_table_builder. Two instances:
//                A (8-byte program, depth 4) and B (4-byte program, depth 2).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bf_jump_table_builder;
    import bf_pkg::*;

    localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

    typedef struct {
        int kind;
        int a;     // write address or err_addr
        int d;     // write data or err_code
        int lat;   // cycles from start to done/err
    } item_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bf_jump_table_builder_if #(.ADDR_W(3)) bus_a ();
    bf_jump_table_builder_if #(.ADDR_W(2)) bus_b ();

    bf_jump_table_builder #(.PROG_ADDR_WIDTH(3), .PROG_LEN(7), .STACK_DEPTH(4)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a.master));
    bf_jump_table_builder #(.PROG_ADDR_WIDTH(2), .PROG_LEN(3), .STACK_DEPTH(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b.master));

    logic [7:0] mem_a [8];
    logic [7:0] mem_b [4];

    always @(posedge clk) begin
        bus_a.prog_rd_data <= mem_a[bus_a.prog_rd_addr];
        bus_b.prog_rd_data <= mem_b[bus_b.prog_rd_addr];
    end

    item_t qa[$];
    item_t qb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ncyc    = 0;
    int    t0 [2];
    bit    prev_fin [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int s, input item_t it);
        if (s == 0) qa.push_back(it); else qb.push_back(it);
    endtask

    task automatic pop_exp(input int s, output item_t it, output bit ok);
        ok = 1'b0;
        it = '{kind: -1, a: 0, d: 0, lat: 0};
        if (s == 0 && qa.size() > 0) begin it = qa.pop_front(); ok = 1'b1; end
        if (s == 1 && qb.size() > 0) begin it = qb.pop_front(); ok = 1'b1; end
    endtask

    // Reference: walk the program once, matching brackets with a queue used
    // as a stack, and list every expected table write and the final outcome.
    task automatic model(input int s, input string p, input int len, input int depth);
        int stk[$];
        int closes = 0;
        for (int i = 0; i <= len; i++) begin
            if (p[i] == "[") begin
                if (stk.size() == depth) begin
                    push_exp(s, '{kind: K_ERR, a: i, d: 2, lat: 2*i + closes + 2});
                    return;
                end
                stk.push_back(i);
            end else if (p[i] == "]") begin
                if (stk.size() == 0) begin
                    push_exp(s, '{kind: K_ERR, a: i, d: 1, lat: 2*i + closes + 2});
                    return;
                end
                push_exp(s, '{kind: K_WR, a: i, d: stk[$], lat: 0});
                push_exp(s, '{kind: K_WR, a: stk[$], d: i, lat: 0});
                void'(stk.pop_back());
                closes++;
            end
        end
        if (stk.size() == 0)
            push_exp(s, '{kind: K_DONE, a: 0, d: 0, lat: 2*(len+1) + closes});
        else
            push_exp(s, '{kind: K_ERR, a: stk[$], d: 3, lat: 2*(len+1) + closes});
    endtask

    task automatic mon(input int s, input bit rstn, input bit st, input bit bsy,
                       input bit we, input int ja, input int jw,
                       input bit dn, input bit er, input int ec, input int ea);
        item_t it;
        bit    ok;
        if (!rstn) begin
            if (we) chk($sformatf("dut%0d jt_we_in_reset", s), 1, 0);
            prev_fin[s] = 1'b0;
            return;
        end
        if (st && !bsy) t0[s] = ncyc;
        if (we) begin
            pop_exp(s, it, ok);
            if (!ok) chk($sformatf("dut%0d unexpected_write_addr", s), ja, -1);
            else begin
                chk($sformatf("dut%0d write_kind", s), K_WR, it.kind);
                chk($sformatf("dut%0d jt_addr", s), ja, it.a);
                chk($sformatf("dut%0d jt_wr", s), jw, it.d);
            end
        end
        if ((dn || er) && !prev_fin[s]) begin
            pop_exp(s, it, ok);
            if (!ok) chk($sformatf("dut%0d unexpected_finish", s), 1, 0);
            else begin
                chk($sformatf("dut%0d finish_kind", s), dn ? K_DONE : K_ERR, it.kind);
                if (it.kind == K_ERR) begin
                    chk($sformatf("dut%0d err_code", s), ec, it.d);
                    chk($sformatf("dut%0d err_addr", s), ea, it.a);
                end
                chk($sformatf("dut%0d latency", s), ncyc - t0[s] - 1, it.lat);
            end
        end
        prev_fin[s] = dn || er;
    endtask

    always @(negedge clk) begin
        ncyc++;
        mon(0, resetn, bus_a.start, bus_a.busy, bus_a.jt_we, int'(bus_a.jt_addr), int'(bus_a.jt_wr),
            bus_a.done, bus_a.err, int'(bus_a.err_code), int'(bus_a.err_addr));
        mon(1, resetn, bus_b.start, bus_b.busy, bus_b.jt_we, int'(bus_b.jt_addr), int'(bus_b.jt_wr),
            bus_b.done, bus_b.err, int'(bus_b.err_code), int'(bus_b.err_addr));
    end

    task automatic set_start(input int s, input logic v);
        if (s == 0) bus_a.start = v; else bus_b.start = v;
    endtask

    task automatic pulse_start(input int s);
        @(posedge clk); #1 set_start(s, 1'b1);
        @(posedge clk); #1 set_start(s, 1'b0);
    endtask

    task automatic load(input int s, input string p);
        for (int i = 0; i < ((s == 0) ? 8 : 4); i++) begin
            if (s == 0) mem_a[i] = p[i]; else mem_b[i] = p[i];
        end
    endtask

    task automatic run_prog(input int s, input string p, input bit mid_start);
        bit fin = 1'b0;
        load(s, p);
        model(s, p, (s == 0) ? 7 : 3, (s == 0) ? 4 : 2);
        pulse_start(s);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            pulse_start(s);
        end
        for (int n = 0; n < 200 && !fin; n++) begin
            @(negedge clk);
            fin = (s == 0) ? (bus_a.done || bus_a.err) : (bus_b.done || bus_b.err);
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout dut%0d prog %s: got no done/err, expected one within 200 cycles", s, p);
        end
        @(negedge clk);
        chk($sformatf("dut%0d pending_expectations", s), (s == 0) ? qa.size() : qb.size(), 0);
        if (s == 0) qa.delete(); else qb.delete();
    endtask

    task automatic check_b_zero(input string tag);
        chk({tag, " busy"},         int'(bus_b.busy), 0);
        chk({tag, " done"},         int'(bus_b.done), 0);
        chk({tag, " err"},          int'(bus_b.err), 0);
        chk({tag, " jt_we"},        int'(bus_b.jt_we), 0);
        chk({tag, " err_code"},     int'(bus_b.err_code), 0);
        chk({tag, " err_addr"},     int'(bus_b.err_addr), 0);
        chk({tag, " prog_rd_addr"}, int'(bus_b.prog_rd_addr), 0);
    endtask

    initial begin
        string ops;
        string rp;
        int    r;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = 8'h2E;
        for (int i = 0; i < 4; i++) mem_b[i] = 8'h2E;

        #12;
        check_b_zero("reset");
        chk("reset A busy", int'(bus_a.busy), 0);
        chk("reset A done", int'(bus_a.done), 0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Directed programs
        run_prog(0, "+[->+<].", 1'b0);
        run_prog(0, "[[[[]]]]", 1'b0);
        run_prog(0, "[[[[[]]]", 1'b0);
        run_prog(0, "[]][....", 1'b0);
        run_prog(1, "[[]]", 1'b0);
        run_prog(1, "]...", 1'b0);
        run_prog(1, "+[[]", 1'b0);
        run_prog(1, "[[[]", 1'b0);

        // Reset in the middle of a scan, after the first table write
        load(1, "[[]]");
        model(1, "[[]]", 3, 2);
        pulse_start(1);
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0;
        #2 check_b_zero("midscan_reset");
        qb.delete();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        // Clean rescan with a start pulse landing while busy
        run_prog(1, "[[]]", 1'b1);

        // Random programs on instance A
        ops = "+-<>.,";
        for (int t = 0; t < 40; t++) begin
            rp = "........";
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 4)      rp.putc(i, "[");
                else if (r < 7) rp.putc(i, "]");
                else            rp.putc(i, ops[int'($urandom_range(0, 5))]);
            end
            run_prog(0, rp, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
